ifetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the instruction decoder/controller. Holds the program counter, issues one single-outstanding request per instruction to instruction memory, and presents the returned 32-bit word with its PC to decode via a valid/ready handshake. Accepts branch/jump redirects from execute and squashes any fetch already in flight.

---
 rtl/ifetch_unit.sv | 100 ++++++++++
 tb/tb_ifetch_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding imem request, and a
// one-entry instruction holding register handshaked to decode; redirects squash in-flight fetches.
module ifetch_unit #(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] NOP      = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             imem_rvalid,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc,
    output logic             inst_valid,
    input  logic             inst_ready
);

    typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pc, pc_nxt;
    logic             discard, discard_nxt;
    logic [WIDTH-1:0] inst_nxt, inst_pc_nxt;
    logic [WIDTH-1:0] redir_tgt;

    assign redir_tgt = {redirect_pc[WIDTH-1:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            discard <= 1'b0;
            inst    <= NOP;
            inst_pc <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            discard <= discard_nxt;
            inst    <= inst_nxt;
            inst_pc <= inst_pc_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        discard_nxt = discard;
        inst_nxt    = inst;
        inst_pc_nxt = inst_pc;
        case (state)
            FETCH: begin
                state_nxt = WAIT;
                // The request for the old pc is already out; its response must be dropped.
                if (redirect_valid) begin
                    pc_nxt      = redir_tgt;
                    discard_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rvalid && redirect_valid) begin
                    pc_nxt      = redir_tgt;
                    discard_nxt = 1'b0;
                    state_nxt   = FETCH;
                end else if (imem_rvalid && discard) begin
                    discard_nxt = 1'b0;
                    state_nxt   = FETCH;
                end else if (imem_rvalid) begin
                    inst_nxt    = imem_rdata;
                    inst_pc_nxt = pc;
                    pc_nxt      = pc + WIDTH'(4);
                    state_nxt   = HOLD;
                end else if (redirect_valid) begin
                    pc_nxt      = redir_tgt;
                    discard_nxt = 1'b1;
                end
            end
            HOLD: begin
                // Redirect wins over consumption: the held instruction is on the wrong path.
                if (redirect_valid) begin
                    pc_nxt    = redir_tgt;
                    inst_nxt  = NOP;
                    state_nxt = FETCH;
                end else if (inst_ready) begin
                    inst_nxt  = NOP;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    assign imem_req   = (state == FETCH);
    assign imem_addr  = pc;
    assign inst_valid = (state == HOLD);

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a latency-programmable memory model plus
// cycle-exact checks of fetch, backpressure, redirects, wrap and async reset.
module tb_ifetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;

    int total = 0;
    int bad   = 0;
    int lat   = 1;
    int n;

    ifetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
        .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'd0) ? 32'h0050_0093 : {16'hC0DE, a[15:0]};
    endfunction

    // Memory model: response lands exactly lat cycles after the request cycle.
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        pend        = 1'b0;
        cnt         = 0;
        paddr       = '0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(paddr);
                        pend        = 1'b0;
                        chk("rsp_in_wait", {30'd0, imem_req, inst_valid}, 32'd0);
                    end
                end
                if (imem_req) begin
                    chk("one_outstanding", {31'd0, pend}, 32'd0);
                    pend  = 1'b1;
                    paddr = imem_addr;
                    cnt   = lat;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Asserts rst between edges, checks the asynchronous effect, releases just after a posedge.
    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, NOP);
        chk("rst_req", {31'd0, imem_req}, 32'd1);
        chk("rst_addr", imem_addr, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!inst_valid && cyc < 20);
        if (!inst_valid) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_req(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!imem_req && cyc < 20);
        if (!imem_req) chk("req_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;

        // Reset and first fetch, L=1, then backpressure
        do_reset();
        step();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'd0);
        step();
        chk("wait_novalid", {31'd0, inst_valid}, 32'd0);
        step();
        chk("first_valid", {31'd0, inst_valid}, 32'd1);
        chk("first_inst", inst, 32'h0050_0093);
        chk("first_pc", inst_pc, 32'd0);
        lat = 2;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_valid", {31'd0, inst_valid}, 32'd1);
            chk("bp_inst", inst, 32'h0050_0093);
            chk("bp_pc", inst_pc, 32'd0);
            chk("bp_noreq", {31'd0, imem_req}, 32'd0);
        end
        inst_ready = 1'b1;
        step();
        chk("bp_req", {31'd0, imem_req}, 32'd1);
        chk("bp_addr", imem_addr, 32'd4);
        chk("bp_nop", inst, NOP);
        chk("bp_drop_valid", {31'd0, inst_valid}, 32'd0);

        // Sequential stream, L=2: one instruction every 4 cycles
        do_reset();
        for (int k = 0; k < 4; k++) begin
            wait_valid(n);
            chk("seq_pc", inst_pc, 32'(4 * k));
            chk("seq_inst", inst, (k == 0) ? 32'h0050_0093 : {16'hC0DE, 16'(4 * k)});
            chk("seq_gap", 32'(n), 32'd4);
        end

        // Redirect in WAIT, L=3
        lat = 3;
        wait_req(n);
        chk("rw_req_addr", imem_addr, 32'h10);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rw_noreq", {31'd0, imem_req}, 32'd0);
            chk("rw_novalid", {31'd0, inst_valid}, 32'd0);
            step();
        end
        chk("rw_req", {31'd0, imem_req}, 32'd1);
        chk("rw_addr", imem_addr, 32'h100);
        wait_valid(n);
        chk("rw_pc", inst_pc, 32'h100);
        chk("rw_inst", inst, 32'hC0DE_0100);

        // Redirect together with rvalid, L=2
        lat = 2;
        wait_req(n);
        chk("rr_req_addr", imem_addr, 32'h104);
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        step();
        redirect_valid = 1'b0;
        chk("rr_req", {31'd0, imem_req}, 32'd1);
        chk("rr_addr", imem_addr, 32'h200);
        chk("rr_novalid", {31'd0, inst_valid}, 32'd0);

        // Redirect with inst_ready in HOLD squashes the held word
        wait_valid(n);
        chk("rh_pc", inst_pc, 32'h200);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        chk("rh_addr", imem_addr, 32'h300);
        chk("rh_req", {31'd0, imem_req}, 32'd1);
        chk("rh_inst", inst, NOP);
        chk("rh_novalid", {31'd0, inst_valid}, 32'd0);

        // Redirect in FETCH to the top of the address space, then wrap
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        wait_req(n);
        chk("wr_gap", 32'(n), 32'd2);
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        wait_valid(n);
        chk("wr_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wr_inst", inst, 32'hC0DE_FFFC);
        wait_req(n);
        chk("wrap_addr", imem_addr, 32'd0);
        wait_valid(n);
        chk("wrap_pc", inst_pc, 32'd0);

        // Async reset mid-WAIT, then restart at RESET_PC with L=3
        lat = 3;
        wait_req(n);
        chk("ar_pre_addr", imem_addr, 32'd4);
        step();
        chk("ar_in_wait", {31'd0, imem_req}, 32'd0);
        do_reset();
        wait_valid(n);
        chk("ar_cycles", 32'(n), 32'd5);
        chk("ar_pc", inst_pc, 32'd0);
        chk("ar_inst", inst, 32'h0050_0093);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=%0d exp=finish", total);
        $fatal(1, "watchdog expired");
    end

endmodule
